// File: rtl/raizing_video_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// raizing_video_pkg : shared pixel types and layer-mixing rule, rev 1.0
// ------------------------------------------------------------------------
package raizing_video_pkg;

  localparam int PRIO_W = 4;
  localparam int COL_W  = 7;
  localparam int IDX_W  = 4;
  localparam int PIX_W  = COL_W + IDX_W;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [COL_W-1:0]  col;
    logic [IDX_W-1:0]  idx;
  } layer_pix_t;

  typedef struct packed {
    logic              valid;
    logic [PRIO_W-1:0] prio;
    logic [PIX_W-1:0]  pix;
  } mix_ent_t;

  // Transparent or disabled pixels collapse to an all-zero invalid entry.
  function automatic mix_ent_t mix_qualify(input layer_pix_t p, input logic en);
    mix_ent_t r;
    r = '0;
    if (en && (p.idx != '0)) begin
      r.valid = 1'b1;
      r.prio  = p.prio;
      r.pix   = {p.col, p.idx};
    end
    return r;
  endfunction

  // Left operand is always the lower layer index, so it keeps ties.
  function automatic mix_ent_t mix_pick(input mix_ent_t a, input mix_ent_t b);
    mix_ent_t r;
    r = '0;
    if (a.valid && b.valid) r = (b.prio > a.prio) ? b : a;
    else if (a.valid)       r = a;
    else if (b.valid)       r = b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/raizing_mix_node.sv
`default_nettype none
// ------------------------------------------------------------------------
// raizing_mix_node : registered two-input priority compare cell, rev 1.0
// ------------------------------------------------------------------------
module raizing_mix_node
  import raizing_video_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     cen_i,
  input  mix_ent_t a_i,
  input  mix_ent_t b_i,
  output mix_ent_t ent_o
);

  mix_ent_t ent_d;
  mix_ent_t ent_q;

  assign ent_d = mix_pick(a_i, b_i);

  always_ff @(posedge clk_i) begin
    if (rst_i)      ent_q <= '0;
    else if (cen_i) ent_q <= ent_d;
  end

  assign ent_o = ent_q;

endmodule
`default_nettype wire

// File: rtl/raizing_layer_mixer.sv
`default_nettype none
// ------------------------------------------------------------------------
// raizing_layer_mixer : N-layer + text pipelined priority compositor, rev 1.0
// ------------------------------------------------------------------------
module raizing_layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int PRIO_W     = 4,
  parameter int COL_W      = 7,
  parameter int IDX_W      = 4,
  parameter int OUT_W      = COL_W + IDX_W
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               PIXEL_CEN,
  input  logic                               ACTIVE,
  input  logic                               FRAME_START,
  input  logic [NUM_LAYERS*(PRIO_W+OUT_W)-1:0] LAYER_PIXELS,
  input  logic [OUT_W-1:0]                   EXTRATEXT_PIXEL,
  input  logic [NUM_LAYERS:0]                LAYER_EN_IN,
  input  logic [OUT_W-1:0]                   BG_PEN_IN,
  output logic [OUT_W-1:0]                   FINAL_PIXEL,
  output logic                               FINAL_VALID
);
  import raizing_video_pkg::*;

  localparam int LPIX_W = PRIO_W + OUT_W;
  localparam int D      = $clog2(NUM_LAYERS);
  localparam int P      = 1 << D;

  logic [NUM_LAYERS:0] layer_en_q;
  logic [OUT_W-1:0]    bg_pen_q;

  mix_ent_t            s0_d [NUM_LAYERS];
  mix_ent_t            s0_q [NUM_LAYERS];
  mix_ent_t            txt_d;
  mix_ent_t            txt_q [0:D];
  logic [D:0]          act_q;

  // Heap-ordered tree: node n is fed by 2n and 2n+1, leaves sit at P..2P-1.
  mix_ent_t            tree_w [1:2*P-1];

  logic [OUT_W-1:0]    final_pix_d;
  logic [OUT_W-1:0]    final_pix_q;
  logic                final_valid_q;

  // Shadow state follows FRAME_START alone so a new mask never splits a frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      layer_en_q <= '1;
      bg_pen_q   <= '0;
    end else if (FRAME_START) begin
      layer_en_q <= LAYER_EN_IN;
      bg_pen_q   <= BG_PEN_IN;
    end
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_qual
    assign s0_d[k] = mix_qualify(layer_pix_t'(LAYER_PIXELS[k*LPIX_W +: LPIX_W]),
                                 layer_en_q[k]);
  end

  assign txt_d = mix_qualify(layer_pix_t'({{PRIO_W{1'b0}}, EXTRATEXT_PIXEL}),
                             layer_en_q[NUM_LAYERS]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_LAYERS; k++) s0_q[k] <= '0;
      for (int j = 0; j <= D; j++) txt_q[j] <= '0;
      act_q <= '0;
    end else if (PIXEL_CEN) begin
      for (int k = 0; k < NUM_LAYERS; k++) s0_q[k] <= s0_d[k];
      txt_q[0] <= txt_d;
      act_q[0] <= ACTIVE;
      for (int j = 1; j <= D; j++) begin
        txt_q[j] <= txt_q[j-1];
        act_q[j] <= act_q[j-1];
      end
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < NUM_LAYERS) begin : g_real
      assign tree_w[P+k] = s0_q[k];
    end else begin : g_pad
      assign tree_w[P+k] = '0;
    end
  end

  for (genvar n = 1; n < P; n++) begin : g_node
    raizing_mix_node u_node (
      .clk_i (CLK),
      .rst_i (RESET),
      .cen_i (PIXEL_CEN),
      .a_i   (tree_w[2*n]),
      .b_i   (tree_w[2*n+1]),
      .ent_o (tree_w[n])
    );
  end

  always_comb begin
    final_pix_d = '0;
    if (act_q[D]) begin
      if (txt_q[D].valid)      final_pix_d = txt_q[D].pix;
      else if (tree_w[1].valid) final_pix_d = tree_w[1].pix;
      else                     final_pix_d = bg_pen_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      final_pix_q   <= '0;
      final_valid_q <= 1'b0;
    end else if (PIXEL_CEN) begin
      final_pix_q   <= final_pix_d;
      final_valid_q <= act_q[D];
    end
  end

  assign FINAL_PIXEL = final_pix_q;
  assign FINAL_VALID = final_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_raizing_layer_mixer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_raizing_layer_mixer : directed bench for the layer mixer, rev 1.0
// ------------------------------------------------------------------------
module tb_raizing_layer_mixer;

  logic        CLK = 1'b0;
  logic        RESET, PIXEL_CEN, ACTIVE, FRAME_START;
  logic [59:0] LAYER_PIXELS;
  logic [10:0] EXTRATEXT_PIXEL, BG_PEN_IN, FINAL_PIXEL;
  logic [4:0]  LAYER_EN_IN;
  logic        FINAL_VALID;

  logic [74:0] sw_pix;
  logic [10:0] fp1, fp3, fp5;
  logic        fv1, fv3, fv5;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  raizing_layer_mixer dut (
    .CLK(CLK), .RESET(RESET), .PIXEL_CEN(PIXEL_CEN), .ACTIVE(ACTIVE),
    .FRAME_START(FRAME_START), .LAYER_PIXELS(LAYER_PIXELS),
    .EXTRATEXT_PIXEL(EXTRATEXT_PIXEL), .LAYER_EN_IN(LAYER_EN_IN),
    .BG_PEN_IN(BG_PEN_IN), .FINAL_PIXEL(FINAL_PIXEL), .FINAL_VALID(FINAL_VALID)
  );

  raizing_layer_mixer #(.NUM_LAYERS(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .PIXEL_CEN(PIXEL_CEN), .ACTIVE(ACTIVE),
    .FRAME_START(FRAME_START), .LAYER_PIXELS(sw_pix[14:0]),
    .EXTRATEXT_PIXEL(EXTRATEXT_PIXEL), .LAYER_EN_IN(2'b11),
    .BG_PEN_IN(BG_PEN_IN), .FINAL_PIXEL(fp1), .FINAL_VALID(fv1)
  );

  raizing_layer_mixer #(.NUM_LAYERS(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .PIXEL_CEN(PIXEL_CEN), .ACTIVE(ACTIVE),
    .FRAME_START(FRAME_START), .LAYER_PIXELS(sw_pix[44:0]),
    .EXTRATEXT_PIXEL(EXTRATEXT_PIXEL), .LAYER_EN_IN(4'hF),
    .BG_PEN_IN(BG_PEN_IN), .FINAL_PIXEL(fp3), .FINAL_VALID(fv3)
  );

  raizing_layer_mixer #(.NUM_LAYERS(5)) dut5 (
    .CLK(CLK), .RESET(RESET), .PIXEL_CEN(PIXEL_CEN), .ACTIVE(ACTIVE),
    .FRAME_START(FRAME_START), .LAYER_PIXELS(sw_pix),
    .EXTRATEXT_PIXEL(EXTRATEXT_PIXEL), .LAYER_EN_IN(6'h3F),
    .BG_PEN_IN(BG_PEN_IN), .FINAL_PIXEL(fp5), .FINAL_VALID(fv5)
  );

  function automatic logic [14:0] lp(input logic [3:0] p, input logic [6:0] c,
                                     input logic [3:0] i);
    return {p, c, i};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // L1 {7,1,9} beats L0 {3,5,2}: expected pixel 0x019.
  localparam logic [59:0] BASE_PIX = {15'd0, 15'd0, 15'h3819, 15'h1852};

  task automatic test_reset;
    RESET = 1'b1; ACTIVE = 1'b1; PIXEL_CEN = 1'b1;
    LAYER_PIXELS = {lp(0,0,0), lp(0,0,0), lp(7,1,9), lp(3,5,2)};
    tick(3);
    n_vec++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: pix=%h valid=%b want 000/0", FINAL_PIXEL, FINAL_VALID);
    end
    RESET = 1'b0;
    tick(3);
    n_vec++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      n_err++; $display("FAIL reset_fill3: pix=%h valid=%b want 000/0", FINAL_PIXEL, FINAL_VALID);
    end
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019 || FINAL_VALID !== 1'b1) begin
      n_err++; $display("FAIL reset_fill4: pix=%h valid=%b want 019/1", FINAL_PIXEL, FINAL_VALID);
    end
  endtask

  task automatic test_priority;
    LAYER_PIXELS = {lp(0,0,0), lp(0,0,0), lp(3,1,9), lp(3,5,2)};
    tick(3);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019) begin
      n_err++; $display("FAIL prio_latency: pix=%h want 019", FINAL_PIXEL);
    end
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h052) begin
      n_err++; $display("FAIL prio_tie: pix=%h want 052", FINAL_PIXEL);
    end
  endtask

  task automatic test_text_bg;
    EXTRATEXT_PIXEL = 11'h7FF;
    tick(4);
    n_vec++;
    if (FINAL_PIXEL !== 11'h7FF) begin
      n_err++; $display("FAIL text_top: pix=%h want 7FF", FINAL_PIXEL);
    end
    EXTRATEXT_PIXEL = 11'h000;
    LAYER_PIXELS = {lp(9,3,0), lp(8,2,0), lp(7,1,0), lp(3,5,0)};
    BG_PEN_IN = 11'h123;
    tick(4);
    n_vec++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b1) begin
      n_err++; $display("FAIL bg_unlatched: pix=%h valid=%b want 000/1", FINAL_PIXEL, FINAL_VALID);
    end
    FRAME_START = 1'b1;
    tick(1);
    FRAME_START = 1'b0;
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h123) begin
      n_err++; $display("FAIL bg_latched: pix=%h want 123", FINAL_PIXEL);
    end
  endtask

  task automatic test_mask;
    LAYER_PIXELS = BASE_PIX;
    LAYER_EN_IN = 5'b11101;
    tick(4);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019) begin
      n_err++; $display("FAIL mask_unlatched: pix=%h want 019", FINAL_PIXEL);
    end
    FRAME_START = 1'b1;
    tick(1);
    FRAME_START = 1'b0;
    tick(3);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019) begin
      n_err++; $display("FAIL mask_inflight: pix=%h want 019", FINAL_PIXEL);
    end
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h052) begin
      n_err++; $display("FAIL mask_applied: pix=%h want 052", FINAL_PIXEL);
    end
    LAYER_EN_IN = 5'b01111;
    EXTRATEXT_PIXEL = 11'h7FF;
    FRAME_START = 1'b1;
    tick(1);
    FRAME_START = 1'b0;
    tick(4);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019) begin
      n_err++; $display("FAIL mask_text_off: pix=%h want 019", FINAL_PIXEL);
    end
    LAYER_EN_IN = 5'b11111;
    EXTRATEXT_PIXEL = 11'h000;
    FRAME_START = 1'b1;
    tick(1);
    FRAME_START = 1'b0;
    tick(4);
  endtask

  task automatic test_blank;
    ACTIVE = 1'b0;
    tick(1);
    ACTIVE = 1'b1;
    tick(2);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019 || FINAL_VALID !== 1'b1) begin
      n_err++; $display("FAIL blank_early: pix=%h valid=%b want 019/1", FINAL_PIXEL, FINAL_VALID);
    end
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      n_err++; $display("FAIL blank_slot: pix=%h valid=%b want 000/0", FINAL_PIXEL, FINAL_VALID);
    end
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019 || FINAL_VALID !== 1'b1) begin
      n_err++; $display("FAIL blank_after: pix=%h valid=%b want 019/1", FINAL_PIXEL, FINAL_VALID);
    end
  endtask

  task automatic test_cen_gaps;
    EXTRATEXT_PIXEL = 11'h7FF;
    PIXEL_CEN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      n_vec++;
      if (FINAL_PIXEL !== 11'h019 || FINAL_VALID !== 1'b1) begin
        n_err++; $display("FAIL cen_frozen[%0d]: pix=%h valid=%b want 019/1", c, FINAL_PIXEL, FINAL_VALID);
      end
    end
    PIXEL_CEN = 1'b1;
    tick(3);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019) begin
      n_err++; $display("FAIL cen_resume3: pix=%h want 019", FINAL_PIXEL);
    end
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h7FF) begin
      n_err++; $display("FAIL cen_resume4: pix=%h want 7FF", FINAL_PIXEL);
    end
    EXTRATEXT_PIXEL = 11'h000;
    tick(4);
  endtask

  task automatic test_sweep;
    logic [74:0] vec [3];
    logic [10:0] ex1 [3];
    logic [10:0] ex3 [3];
    logic [10:0] ex5 [3];
    logic [10:0] e1, e3, e5;
    vec[0] = {lp(9,5,5), lp(1,4,4), lp(5,3,3), lp(5,2,2), lp(2,1,1)};
    vec[1] = {lp(15,8,0), lp(4,7,7), lp(7,0,0), lp(0,6,6), lp(0,0,0)};
    vec[2] = {lp(15,1,1), lp(3,3,3), lp(15,2,2), lp(14,1,1), lp(15,9,10)};
    ex1[0] = 11'h011; ex1[1] = 11'h123; ex1[2] = 11'h09A;
    ex3[0] = 11'h022; ex3[1] = 11'h066; ex3[2] = 11'h09A;
    ex5[0] = 11'h055; ex5[1] = 11'h077; ex5[2] = 11'h09A;
    sw_pix = '0;
    tick(6);
    // Each result must surface exactly D+2 enables after its input (D = 0, 2, 3).
    for (int s = 0; s < 8; s++) begin
      sw_pix = (s < 3) ? vec[s] : 75'd0;
      tick(1);
      e1 = (s - 1 >= 0 && s - 1 < 3) ? ex1[s-1] : 11'h123;
      e3 = (s - 3 >= 0 && s - 3 < 3) ? ex3[s-3] : 11'h123;
      e5 = (s - 4 >= 0 && s - 4 < 3) ? ex5[s-4] : 11'h123;
      n_vec++;
      if (fp1 !== e1 || fv1 !== 1'b1) begin
        n_err++; $display("FAIL sweep_n1[%0d]: pix=%h valid=%b want %h/1", s, fp1, fv1, e1);
      end
      n_vec++;
      if (fp3 !== e3 || fv3 !== 1'b1) begin
        n_err++; $display("FAIL sweep_n3[%0d]: pix=%h valid=%b want %h/1", s, fp3, fv3, e3);
      end
      n_vec++;
      if (fp5 !== e5 || fv5 !== 1'b1) begin
        n_err++; $display("FAIL sweep_n5[%0d]: pix=%h valid=%b want %h/1", s, fp5, fv5, e5);
      end
    end
  endtask

  task automatic test_reset_mid;
    LAYER_PIXELS = BASE_PIX;
    tick(4);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    n_vec++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      n_err++; $display("FAIL rstmid_clear: pix=%h valid=%b want 000/0", FINAL_PIXEL, FINAL_VALID);
    end
    tick(3);
    n_vec++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      n_err++; $display("FAIL rstmid_fill3: pix=%h valid=%b want 000/0", FINAL_PIXEL, FINAL_VALID);
    end
    tick(1);
    n_vec++;
    if (FINAL_PIXEL !== 11'h019 || FINAL_VALID !== 1'b1) begin
      n_err++; $display("FAIL rstmid_resume: pix=%h valid=%b want 019/1", FINAL_PIXEL, FINAL_VALID);
    end
  endtask

  initial begin
    RESET = 1'b1; PIXEL_CEN = 1'b1; ACTIVE = 1'b1; FRAME_START = 1'b0;
    LAYER_PIXELS = '0; EXTRATEXT_PIXEL = '0; LAYER_EN_IN = 5'b11111;
    BG_PEN_IN = '0; sw_pix = '0;
    test_reset();
    test_priority();
    test_text_bg();
    test_mask();
    test_blank();
    test_cen_gaps();
    test_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
